// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: issues one memory read at a time,
// holds the returned word for the decoder, and handles redirects and misaligned targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_ERROR
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misaligned_q, misaligned_d;

    logic redir_ok;
    logic redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        misaligned_d  = misaligned_q;

        if (state_q != S_ERROR && redir_bad) begin
            state_d      = S_ERROR;
            misaligned_d = 1'b1;
            discard_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (!mem_req_q) begin
                        // First cycle out of reset: the request has not been launched yet.
                        mem_req_d  = 1'b1;
                        pc_d       = redir_ok ? redirect_pc : pc_q;
                        mem_addr_d = redir_ok ? redirect_pc : pc_q;
                    end else begin
                        state_d = S_WAIT;
                        if (redir_ok) begin
                            pc_d      = redirect_pc;
                            discard_d = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid && (discard_q || redir_ok)) begin
                        discard_d  = 1'b0;
                        state_d    = S_FETCH;
                        mem_req_d  = 1'b1;
                        pc_d       = redir_ok ? redirect_pc : pc_q;
                        mem_addr_d = redir_ok ? redirect_pc : pc_q;
                    end else if (mem_rvalid) begin
                        instr_d       = mem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end else if (redir_ok) begin
                        pc_d      = redirect_pc;
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect wins over pc+4 even when the decoder accepts this cycle.
                    if (redir_ok) begin
                        pc_d       = redirect_pc;
                        mem_addr_d = redirect_pc;
                        mem_req_d  = 1'b1;
                        state_d    = S_FETCH;
                    end else if (instr_ready) begin
                        pc_d       = pc_q + 32'd4;
                        mem_addr_d = pc_q + 32'd4;
                        mem_req_d  = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        instr_valid_d = 1'b1;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_ERROR;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed latency/redirect/error cases, then a random
// phase where a scoreboard of expected fetch addresses is checked by a separate monitor.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;

    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
    endtask

    // Monitor: pops the scoreboard on every decoder handshake and checks hold stability.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", {31'b0, instr_valid}, 32'd1);
                check("hold_instr", instr, prev_instr);
                check("hold_pc", instr_pc, prev_pc);
            end
            if (instr_valid && instr_ready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e);
                    check("sb_instr", instr, mem_fn(e));
                end
            end
            prev_hold  = instr_valid && !instr_ready && !redirect;
            prev_instr = instr;
            prev_pc    = instr_pc;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        bit          pending;
        int          age;
        int          delay;
        logic [31:0] req_addr;
        logic [31:0] saved_instr;
        logic [31:0] saved_pc;
        logic [31:0] tgt;
        logic        hs;

        rst = 1'b1;
        idle_inputs();
        repeat (2) step();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);

        // Release reset with a stale response on the bus; it must be ignored.
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADB_AD00;
        step();
        mem_rvalid = 1'b0;
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        check("stale_ignored", {31'b0, instr_valid}, 32'd0);
        step();
        check("req_one_cycle", {31'b0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0050_0093;
        step();
        mem_rvalid = 1'b0;
        check("lat_valid", {31'b0, instr_valid}, 32'd1);
        check("lat_instr", instr, 32'h0050_0093);
        check("lat_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("next_req", {31'b0, mem_req}, 32'd1);
        check("next_addr", mem_addr, 32'h4);

        // Decoder stalls for five cycles.
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        step();
        mem_rvalid  = 1'b0;
        saved_instr = instr;
        saved_pc    = instr_pc;
        check("stall_instr0", instr, 32'h1111_1111);
        check("stall_pc0", instr_pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_instr", instr, saved_instr);
            check("stall_pc", instr_pc, saved_pc);
            check("stall_no_req", {31'b0, mem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("stall_req", {31'b0, mem_req}, 32'd1);
        check("stall_addr", mem_addr, 32'h8);

        // Redirect while waiting; the late response must be discarded.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        check("disc_valid", {31'b0, instr_valid}, 32'd0);
        check("disc_req", {31'b0, mem_req}, 32'd1);
        check("disc_addr", mem_addr, 32'h100);

        // Redirect coincident with the response.
        step();
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        idle_inputs();
        check("coinc_valid", {31'b0, instr_valid}, 32'd0);
        check("coinc_req", {31'b0, mem_req}, 32'd1);
        check("coinc_addr", mem_addr, 32'h40);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = mem_fn(32'h40);
        step();
        mem_rvalid = 1'b0;
        check("tgt_pc", instr_pc, 32'h40);
        check("tgt_instr", instr, mem_fn(32'h40));

        // Redirect in hold together with a handshake, then pc wrap.
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        check("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
        check("hold_redir_req", {31'b0, mem_req}, 32'd1);
        check("hold_redir_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = mem_fn(32'hFFFF_FFFC);
        step();
        mem_rvalid = 1'b0;
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("wrap_req", {31'b0, mem_req}, 32'd1);
        check("wrap_addr", mem_addr, 32'h0);

        // Random phase against the scoreboard.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        pending = 1'b0;
        age     = 0;
        delay   = 1;
        req_addr = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            idle_inputs();
            if (mem_req) begin
                check("one_outstanding", {31'b0, pending}, 32'd0);
                pending  = 1'b1;
                age      = 0;
                delay    = int'($urandom_range(1, 3));
                req_addr = mem_addr;
            end else if (pending) begin
                age++;
                if (age >= delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_fn(req_addr);
                    pending    = 1'b0;
                end
            end else if (instr_valid && ($urandom_range(0, 3) == 0)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~mem_fn(instr_pc);
            end
            instr_ready = $urandom_range(0, 1) == 1;
            hs = instr_valid && instr_ready;
            if ($urandom_range(0, 9) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                  : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                redirect    = 1'b1;
                redirect_pc = tgt;
                if (hs && exp_q.size() > 0) begin
                    logic [31:0] head;
                    head = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(head);
                end else begin
                    exp_q.delete();
                end
                exp_q.push_back(tgt);
            end else if (hs && exp_q.size() > 0) begin
                exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
            end
        end
        idle_inputs();
        step();
        mon_en = 1'b0;
        check("enough_handshakes", {31'b0, handshakes > 200}, 32'd1);

        // Misaligned redirect locks the unit until reset.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        idle_inputs();
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        check("mis_req", {31'b0, mem_req}, 32'd0);
        check("mis_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            mem_rvalid  = $urandom_range(0, 1) == 1;
            mem_rdata   = $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            redirect    = $urandom_range(0, 1) == 1;
            redirect_pc = {$urandom_range(0, 255), 2'b00};
            step();
            check("err_req", {31'b0, mem_req}, 32'd0);
            check("err_valid", {31'b0, instr_valid}, 32'd0);
            check("err_flag", {31'b0, misaligned}, 32'd1);
        end
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("err_reset", {31'b0, misaligned}, 32'd0);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
